// File: rtl/hyper_ram_responder.sv
// hyper_ram_responder: device-side HyperRAM responder on a pre-deserialised
// link (one clk_i cycle = one CK period = one 16-bit DDR word).
// Decodes the 48-bit CA, waits the CR0-selected initial latency, then serves
// bursts from an internal word array or the ID0/CR0 register space.
// Optional feature macro: HYPER_RESP_WRAP_EN enables wrapped bursts (CA[45]=0);
// without it every burst is linear.
module hyper_ram_responder #(
    parameter int          MemAddrWidth = 10,
    parameter logic [15:0] IdReg0       = 16'h0C81,
    parameter logic [15:0] Cr0Reset     = 16'h8F1F
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cs_ni,
    input  logic [15:0] dq_i,
    input  logic [1:0]  rwds_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic [1:0]  rwds_o,
    output logic        rwds_oe_o
);

    localparam int AW = MemAddrWidth;

    typedef enum logic [2:0] {S_IDLE, S_CA, S_LAT, S_RD, S_WR, S_HOLD} state_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_ID0, SEL_CR0} reg_sel_t;

    state_t          r_state, w_state_nxt;
    reg_sel_t        r_reg_sel, w_reg_sel;
    logic [15:0]     r_ca0, r_ca1;
    logic            r_ca_cnt;
    logic [4:0]      r_lat_cnt;
    logic [AW-1:0]   r_addr, w_addr_inc, w_addr_nxt;
    logic            r_rd, r_reg;
    logic [15:0]     r_cr0;
    logic [15:0]     r_mem [0:(1<<AW)-1];
    logic [47:0]     w_ca;
    logic [31:0]     w_waddr;
    logic [3:0]      w_lat_l;
    logic [4:0]      w_ltot;
    logic [15:0]     w_rdata;
    logic            w_unused;

    // Full CA as seen on the c2 cycle: two captured words plus the live third word
    assign w_ca       = {r_ca0, r_ca1, dq_i};
    assign w_waddr    = {w_ca[44:16], w_ca[2:0]};
    assign w_addr_inc = r_addr + AW'(1);

`ifdef HYPER_RESP_WRAP_EN
    logic          r_wrap;
    logic [AW-1:0] w_mask;

    // Wrap group size from CR0[1:0]; the high address bits are held
    always_comb begin
        case (r_cr0[1:0])
            2'b00:   w_mask = AW'(63);
            2'b01:   w_mask = AW'(31);
            2'b10:   w_mask = AW'(7);
            default: w_mask = AW'(15);
        endcase
        w_addr_nxt = r_wrap ? ((r_addr & ~w_mask) | (w_addr_inc & w_mask)) : w_addr_inc;
    end

    // Burst type latched at CA decode
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_wrap <= 1'b0;
        else if (r_state == S_CA && r_ca_cnt && !cs_ni)
            r_wrap <= ~w_ca[45];
    end

    assign w_unused = &{1'b0, w_ca[15:3]};
`else
    assign w_addr_nxt = w_addr_inc;
    assign w_unused   = &{1'b0, w_ca[15:3], w_ca[45]};
`endif

    // Initial latency from CR0; doubled when CR0[3] requests 2x latency
    always_comb begin
        case (r_cr0[7:4])
            4'b0000: w_lat_l = 4'd5;
            4'b0001: w_lat_l = 4'd6;
            4'b1110: w_lat_l = 4'd3;
            4'b1111: w_lat_l = 4'd4;
            default: w_lat_l = 4'd6;
        endcase
        w_ltot = r_cr0[3] ? {w_lat_l, 1'b0} : {1'b0, w_lat_l};
    end

    // Register-space decode uses the full, untruncated word address
    always_comb begin
        if (w_waddr == 32'h0000_0000)      w_reg_sel = SEL_ID0;
        else if (w_waddr == 32'h0000_0800) w_reg_sel = SEL_CR0;
        else                               w_reg_sel = SEL_NONE;
    end

    // Read data source: register file or word array
    always_comb begin
        if (r_reg) begin
            case (r_reg_sel)
                SEL_ID0: w_rdata = IdReg0;
                SEL_CR0: w_rdata = r_cr0;
                default: w_rdata = 16'h0000;
            endcase
        end else begin
            w_rdata = r_mem[r_addr];
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state and link outputs; deasserted chip select always returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        dq_o        = 16'h0000;
        dq_oe_o     = 1'b0;
        rwds_o      = 2'b00;
        rwds_oe_o   = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_CA;
            S_CA: begin
                rwds_oe_o = 1'b1;
                rwds_o    = {2{r_cr0[3]}};
                if (r_ca_cnt)
                    w_state_nxt = (!w_ca[47] && w_ca[46]) ? S_WR : S_LAT;
            end
            S_LAT: begin
                if (r_lat_cnt == 5'd0)
                    w_state_nxt = r_rd ? S_RD : S_WR;
            end
            S_RD: begin
                dq_o      = w_rdata;
                dq_oe_o   = 1'b1;
                rwds_o    = 2'b10;
                rwds_oe_o = 1'b1;
            end
            S_WR: begin
                if (r_reg) w_state_nxt = S_HOLD;
            end
            S_HOLD: w_state_nxt = S_HOLD;
            default: w_state_nxt = S_IDLE;
        endcase
        if (cs_ni) w_state_nxt = S_IDLE;
    end

    // CA capture, decode, latency count, address stepping and CR0 writes
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ca0     <= 16'h0000;
            r_ca1     <= 16'h0000;
            r_ca_cnt  <= 1'b0;
            r_lat_cnt <= 5'd0;
            r_addr    <= '0;
            r_rd      <= 1'b0;
            r_reg     <= 1'b0;
            r_reg_sel <= SEL_NONE;
            r_cr0     <= Cr0Reset;
        end else if (!cs_ni) begin
            case (r_state)
                S_IDLE: begin
                    r_ca0    <= dq_i;
                    r_ca_cnt <= 1'b0;
                end
                S_CA: begin
                    if (!r_ca_cnt) begin
                        r_ca1    <= dq_i;
                        r_ca_cnt <= 1'b1;
                    end else begin
                        r_rd      <= w_ca[47];
                        r_reg     <= w_ca[46];
                        r_reg_sel <= w_reg_sel;
                        r_addr    <= w_waddr[AW-1:0];
                        r_lat_cnt <= w_ltot - 5'd1;
                    end
                end
                S_LAT: begin
                    if (r_lat_cnt != 5'd0) r_lat_cnt <= r_lat_cnt - 5'd1;
                end
                S_RD: begin
                    if (!r_reg) r_addr <= w_addr_nxt;
                end
                S_WR: begin
                    if (r_reg) begin
                        if (r_reg_sel == SEL_CR0) r_cr0 <= dq_i;
                    end else begin
                        r_addr <= w_addr_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word array write with per-byte RWDS masking; contents are not reset
    always_ff @(posedge clk_i) begin
        if (r_state == S_WR && !cs_ni && !r_reg) begin
            if (!rwds_i[1]) r_mem[r_addr][15:8] <= dq_i[15:8];
            if (!rwds_i[0]) r_mem[r_addr][7:0]  <= dq_i[7:0];
        end
    end

endmodule

// File: tb/tb_hyper_ram_responder.sv
// tb_hyper_ram_responder: directed bench for hyper_ram_responder.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Latency is counted in cycles after c2 (first data on c2+N).
module tb_hyper_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic [15:0] dq_i;
    logic [1:0]  rwds_i;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic [1:0]  rwds_o;
    logic        rwds_oe_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wd [0:15];
    logic [1:0]  wm [0:15];
    logic [15:0] rd [0:15];
    int          lat_obs;
    logic [1:0]  ca_rwds;
    logic        ca_oe;
    logic [1:0]  rd_strobe;

    hyper_ram_responder dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .cs_ni    (cs_n),
        .dq_i     (dq_i),
        .rwds_i   (rwds_i),
        .dq_o     (dq_o),
        .dq_oe_o  (dq_oe_o),
        .rwds_o   (rwds_o),
        .rwds_oe_o(rwds_oe_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Three CA words; RWDS seen during c1 is recorded
    task automatic send_ca(input logic [47:0] ca);
        cs_n = 1'b0; rwds_i = 2'b00;
        dq_i = ca[47:32]; tick();
        dq_i = ca[31:16];
        @(negedge clk); ca_rwds = rwds_o; ca_oe = rwds_oe_o;
        tick();
        dq_i = ca[15:0]; tick();
        dq_i = 16'h0000;
    endtask

    task automatic do_read(input logic [47:0] ca, input int n);
        send_ca(ca);
        lat_obs = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dq_oe_o) begin lat_obs = k; break; end
            tick();
        end
        if (lat_obs < 0) begin
            n_cmp++; n_bad++;
            $display("FAIL read_timeout ca=%h no dq_oe_o within 40 cycles", ca);
            cs_n = 1'b1; tick();
        end else begin
            rd[0] = dq_o; rd_strobe = rwds_o;
            for (int i = 1; i < n; i++) begin
                tick(); @(negedge clk); rd[i] = dq_o;
            end
            cs_n = 1'b1;
            tick();
        end
    endtask

    task automatic do_write(input logic [47:0] ca, input int n, input int lat);
        send_ca(ca);
        repeat (lat) tick();
        for (int i = 0; i < n; i++) begin
            dq_i = wd[i]; rwds_i = wm[i]; tick();
        end
        cs_n = 1'b1; dq_i = 16'h0000; rwds_i = 2'b00;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs_n = 1'b1; dq_i = 16'h0000; rwds_i = 2'b00;
        #12;
        n_cmp++; if (dq_o !== 16'h0000) begin n_bad++; $display("FAIL reset_dq got %h exp 0000", dq_o); end
        n_cmp++; if (dq_oe_o !== 1'b0) begin n_bad++; $display("FAIL reset_dq_oe got %b exp 0", dq_oe_o); end
        n_cmp++; if (rwds_o !== 2'b00) begin n_bad++; $display("FAIL reset_rwds got %b exp 00", rwds_o); end
        n_cmp++; if (rwds_oe_o !== 1'b0) begin n_bad++; $display("FAIL reset_rwds_oe got %b exp 0", rwds_oe_o); end
        @(negedge clk); rst_n = 1'b1;
        tick(); tick();
    endtask

    // Reset CR0 = 8F1F: L=6, 2x -> first data at c2+13
    task automatic test_id0();
        do_read(48'hC000_0000_0000, 2);
        n_cmp++; if (ca_oe !== 1'b1) begin n_bad++; $display("FAIL id0_ca_rwds_oe got %b exp 1", ca_oe); end
        n_cmp++; if (ca_rwds !== 2'b11) begin n_bad++; $display("FAIL id0_ca_rwds got %b exp 11", ca_rwds); end
        n_cmp++; if (lat_obs !== 13) begin n_bad++; $display("FAIL id0_latency got %0d exp 13", lat_obs); end
        n_cmp++; if (rd[0] !== 16'h0C81) begin n_bad++; $display("FAIL id0_data got %h exp 0c81", rd[0]); end
        n_cmp++; if (rd[1] !== 16'h0C81) begin n_bad++; $display("FAIL id0_same_addr got %h exp 0c81", rd[1]); end
        n_cmp++; if (rd_strobe !== 2'b10) begin n_bad++; $display("FAIL id0_strobe got %b exp 10", rd_strobe); end
    endtask

    task automatic test_cr0();
        // 8FE7: L=3 (code 1110), 1x -> c2+4; mask ignored for register writes
        wd[0] = 16'h8FE7; wm[0] = 2'b11;
        do_write(48'h6000_0100_0000, 1, 0);
        do_read(48'hE000_0100_0000, 1);
        n_cmp++; if (rd[0] !== 16'h8FE7) begin n_bad++; $display("FAIL cr0_rb1 got %h exp 8fe7", rd[0]); end
        n_cmp++; if (lat_obs !== 4) begin n_bad++; $display("FAIL cr0_lat3x1 got %0d exp 4", lat_obs); end
        n_cmp++; if (ca_rwds !== 2'b00) begin n_bad++; $display("FAIL cr0_ca_rwds1x got %b exp 00", ca_rwds); end
        // 8F0F: L=5, 2x -> c2+11
        wd[0] = 16'h8F0F; wm[0] = 2'b00;
        do_write(48'h6000_0100_0000, 1, 0);
        do_read(48'hE000_0100_0000, 1);
        n_cmp++; if (rd[0] !== 16'h8F0F) begin n_bad++; $display("FAIL cr0_rb2 got %h exp 8f0f", rd[0]); end
        n_cmp++; if (lat_obs !== 11) begin n_bad++; $display("FAIL cr0_lat5x2 got %0d exp 11", lat_obs); end
        // 8F17: L=6, 1x -> c2+7, used for the rest of the run
        wd[0] = 16'h8F17;
        do_write(48'h6000_0100_0000, 1, 0);
        // Write to an unmapped register address must be dropped
        wd[0] = 16'h1234;
        do_write(48'h6000_0000_0001, 1, 0);
        do_read(48'hE000_0100_0000, 1);
        n_cmp++; if (rd[0] !== 16'h8F17) begin n_bad++; $display("FAIL cr0_rb3 got %h exp 8f17", rd[0]); end
        n_cmp++; if (lat_obs !== 7) begin n_bad++; $display("FAIL cr0_lat6x1 got %0d exp 7", lat_obs); end
        n_cmp++; if (ca_rwds !== 2'b00) begin n_bad++; $display("FAIL cr0_ca_rwds got %b exp 00", ca_rwds); end
        do_read(48'hC000_0000_0001, 1);
        n_cmp++; if (rd[0] !== 16'h0000) begin n_bad++; $display("FAIL reg_other got %h exp 0000", rd[0]); end
    endtask

    task automatic test_linear_wr();
        logic [15:0] exp_v [0:3];
        exp_v[0] = 16'h1111; exp_v[1] = 16'h22CD; exp_v[2] = 16'h3333; exp_v[3] = 16'h4444;
        wd[0] = 16'hABCD; wm[0] = 2'b00;
        do_write(48'h2000_0002_0001, 1, 6);
        wd[0] = 16'h1111; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
        wm[0] = 2'b00;    wm[1] = 2'b01;    wm[2] = 2'b00;    wm[3] = 2'b00;
        do_write(48'h2000_0002_0000, 4, 6);
        do_read(48'hA000_0002_0000, 4);
        n_cmp++; if (lat_obs !== 7) begin n_bad++; $display("FAIL lin_latency got %0d exp 7", lat_obs); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (rd[i] !== exp_v[i]) begin n_bad++; $display("FAIL lin_word%0d got %h exp %h", i, rd[i], exp_v[i]); end
        end
    endtask

    task automatic test_addr_wrap();
        wd[0] = 16'hA001; wd[1] = 16'hA002; wd[2] = 16'hA003;
        wm[0] = 2'b00; wm[1] = 2'b00; wm[2] = 2'b00;
        do_write(48'h2000_007F_0007, 3, 6);
        do_read(48'hA000_007F_0007, 3);
        n_cmp++; if (rd[0] !== 16'hA001) begin n_bad++; $display("FAIL top_3ff got %h exp a001", rd[0]); end
        n_cmp++; if (rd[1] !== 16'hA002) begin n_bad++; $display("FAIL top_000 got %h exp a002", rd[1]); end
        n_cmp++; if (rd[2] !== 16'hA003) begin n_bad++; $display("FAIL top_001 got %h exp a003", rd[2]); end
        do_read(48'hA000_0000_0000, 1);
        n_cmp++; if (rd[0] !== 16'hA002) begin n_bad++; $display("FAIL top_direct0 got %h exp a002", rd[0]); end
    endtask

    task automatic test_abort();
        // One CA word then chip select released
        cs_n = 1'b0; dq_i = 16'hA000; tick();
        cs_n = 1'b1; dq_i = 16'h0000; tick();
        @(negedge clk);
        n_cmp++; if (rwds_oe_o !== 1'b0) begin n_bad++; $display("FAIL abort_ca_rwds_oe got %b exp 0", rwds_oe_o); end
        tick();
        // Write aborted on its first data word must not land
        send_ca(48'h2000_0002_0000);
        repeat (6) tick();
        dq_i = 16'hDEAD; cs_n = 1'b1; tick();
        dq_i = 16'h0000;
        do_read(48'hA000_0002_0000, 4);
        n_cmp++; if (lat_obs !== 7) begin n_bad++; $display("FAIL abort_latency got %0d exp 7", lat_obs); end
        n_cmp++; if (rd[0] !== 16'h1111) begin n_bad++; $display("FAIL abort_word0 got %h exp 1111", rd[0]); end
        n_cmp++; if (rd[3] !== 16'h4444) begin n_bad++; $display("FAIL abort_word3 got %h exp 4444", rd[3]); end
        @(negedge clk);
        n_cmp++; if (dq_oe_o !== 1'b0) begin n_bad++; $display("FAIL abort_dq_oe_drop got %b exp 0", dq_oe_o); end
        n_cmp++; if (rwds_oe_o !== 1'b0) begin n_bad++; $display("FAIL abort_rwds_oe_drop got %b exp 0", rwds_oe_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        wd[0] = 16'hBEEF; wm[0] = 2'b00;
        do_write(48'h2000_0004_0000, 1, 6);
        do_read(48'hA000_0004_0000, 1);
        n_cmp++; if (rd[0] !== 16'hBEEF) begin n_bad++; $display("FAIL raw1 got %h exp beef", rd[0]); end
        wd[0] = 16'hCAFE;
        do_write(48'h2000_0004_0000, 1, 6);
        do_read(48'hA000_0004_0000, 1);
        n_cmp++; if (rd[0] !== 16'hCAFE) begin n_bad++; $display("FAIL raw2 got %h exp cafe", rd[0]); end
    endtask

    task automatic test_wrap();
        logic [15:0] a;
        logic [15:0] e;
        for (int i = 0; i < 16; i++) begin wd[i] = 16'h5000 + 16'(i); wm[i] = 2'b00; end
        do_write(48'h2000_0002_0000, 16, 6);
        // CR0[1:0]=10 -> 8-word groups; L=6, 1x
        wd[0] = 16'h8F16; wm[0] = 2'b00;
        do_write(48'h6000_0100_0000, 1, 0);
        do_read(48'h8000_0002_0006, 10);
        n_cmp++; if (lat_obs !== 7) begin n_bad++; $display("FAIL wrap_latency got %0d exp 7", lat_obs); end
        for (int i = 0; i < 10; i++) begin
`ifdef HYPER_RESP_WRAP_EN
            a = 16'h0010 | ((16'h0006 + 16'(i)) & 16'h0007);
`else
            a = 16'h0016 + 16'(i);
`endif
            e = 16'h5000 + (a - 16'h0010);
            n_cmp++;
            if (rd[i] !== e) begin n_bad++; $display("FAIL wrap_word%0d got %h exp %h", i, rd[i], e); end
        end
    endtask

    initial begin
        test_reset();
        test_id0();
        test_cr0();
        test_linear_wr();
        test_addr_wrap();
        test_abort();
        test_back_to_back();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
